// File: rtl/ifetch_unit_pkg.sv
// Shared core definitions for the fetch front end.
// Holds datapath width, reset PC and the fetch-entry type used by decode.
package ifetch_unit_pkg;

   localparam int unsigned CORE_XLEN = 32;
   localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;
   localparam int unsigned FQ_DEPTH = 2;

   typedef struct packed {
      logic [CORE_XLEN-1:0] pc;
      logic [CORE_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// Two-entry {pc, instr} queue between fetch and decode.
// Push/pop may coincide; flush empties it and rewinds the pointers.
module fetch_queue
   import ifetch_unit_pkg::*;
#(
   parameter int unsigned WIDTH = CORE_XLEN
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] push_pc_i,
   input  logic [WIDTH-1:0] push_instr_i,
   output logic [1:0]       count_o,
   output logic [WIDTH-1:0] head_pc_o,
   output logic [WIDTH-1:0] head_instr_o
);

   logic [FQ_DEPTH-1:0][WIDTH-1:0] pc_q, pc_d;
   logic [FQ_DEPTH-1:0][WIDTH-1:0] instr_q, instr_d;
   logic                           rd_q, rd_d;
   logic                           wr_q, wr_d;
   logic [1:0]                     cnt_q, cnt_d;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         rd_d  = 1'b0;
         wr_d  = 1'b0;
         cnt_d = 2'd0;
      end else begin
         if (push_i) begin
            pc_d[wr_q]    = push_pc_i;
            instr_d[wr_q] = push_instr_i;
            wr_d          = ~wr_q;
         end
         if (pop_i) begin
            rd_d = ~rd_q;
         end
         unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // State registers; reset clears contents so outputs read zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q    <= '0;
         instr_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         cnt_q   <= 2'd0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign count_o      = cnt_q;
   assign head_pc_o    = pc_q[rd_q];
   assign head_instr_o = instr_q[rd_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC sequencing, redirects and a 2-entry output queue.
// Fetch is gated by queue space; a redirect flushes and reloads PC.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int unsigned      WIDTH    = CORE_XLEN,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(CORE_RESET_PC)
) (
   input  logic             CLK,
   input  logic             RST,
   output logic [WIDTH-1:0] PC,
   input  logic [WIDTH-1:0] instruction,
   input  logic             fetch_en,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
   output logic [WIDTH-1:0] out_pc
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [1:0]       count;
   logic             pop;
   logic             fetch;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;
   assign fetch     = fetch_en & ~redirect_valid
                    & ((count != 2'd2) | pop);

   // Redirect wins over sequential fetch; low two bits forced to zero.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_target & ~WIDTH'(3);
      end else if (fetch) begin
         pc_d = pc_q + WIDTH'(4);
      end
   end

   // PC register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign PC = pc_q;

   fetch_queue #(
      .WIDTH(WIDTH)
   ) u_queue (
      .clk_i       (CLK),
      .rst_i       (RST),
      .push_i      (fetch),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .push_pc_i   (pc_q),
      .push_instr_i(instruction),
      .count_o     (count),
      .head_pc_o   (out_pc),
      .head_instr_o(out_instr)
   );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: vector table plus reset/wrap sequences.
// Instruction memory is modelled as PC xor a constant.
module tb_ifetch_unit;

   localparam logic [31:0] K = 32'hC0DE_5A5A;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] PC, instruction, redirect_target, out_instr, out_pc;
   logic        fetch_en, redirect_valid, out_valid, out_ready;

   logic [31:0] PC2, instruction2, out_instr2, out_pc2;
   logic        fe2, rdy2, out_valid2;
   logic        rv2 = 1'b0;
   logic [31:0] tgt2 = 32'h0;

   int pass_cnt = 0;
   int total_cnt = 0;
   int acc10 = 0;
   int seen14 = 0;

   always #5 CLK = ~CLK;

   assign instruction  = PC ^ K;
   assign instruction2 = PC2 ^ K;

   ifetch_unit u_dut (
      .CLK            (CLK),
      .RST            (RST),
      .PC             (PC),
      .instruction    (instruction),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   ifetch_unit #(
      .WIDTH   (32),
      .RESET_PC(32'hFFFF_FFF8)
   ) u_wrap (
      .CLK            (CLK),
      .RST            (RST),
      .PC             (PC2),
      .instruction    (instruction2),
      .fetch_en       (fe2),
      .redirect_valid (rv2),
      .redirect_target(tgt2),
      .out_valid      (out_valid2),
      .out_ready      (rdy2),
      .out_instr      (out_instr2),
      .out_pc         (out_pc2)
   );

   always @(negedge CLK) begin
      if (!RST && out_valid && out_ready && out_pc == 32'h10)
         acc10++;
      if (!RST && out_valid && out_pc == 32'h14)
         seen14++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         pass_cnt++;
   endtask

   typedef struct {
      logic        rst;
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [31:0] tgt;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] ePC;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   initial begin
      // rst fe rdy rv tgt | valid out_pc PC
      tbl[0]  = '{0, 1, 1, 0, 32'h0,   1, 32'h0,   32'h4};
      tbl[1]  = '{0, 1, 1, 0, 32'h0,   1, 32'h4,   32'h8};
      tbl[2]  = '{0, 1, 1, 0, 32'h0,   1, 32'h8,   32'hC};
      tbl[3]  = '{0, 1, 1, 0, 32'h0,   1, 32'hC,   32'h10};
      tbl[4]  = '{0, 1, 0, 0, 32'h0,   1, 32'hC,   32'h14};
      tbl[5]  = '{0, 1, 0, 0, 32'h0,   1, 32'hC,   32'h14};
      tbl[6]  = '{0, 1, 0, 1, 32'h3B,  0, 32'h0,   32'h38};
      tbl[7]  = '{0, 1, 1, 0, 32'h0,   1, 32'h38,  32'h3C};
      tbl[8]  = '{0, 1, 1, 1, 32'h10,  0, 32'h0,   32'h10};
      tbl[9]  = '{0, 1, 0, 0, 32'h0,   1, 32'h10,  32'h14};
      tbl[10] = '{0, 1, 0, 0, 32'h0,   1, 32'h10,  32'h18};
      tbl[11] = '{0, 1, 1, 1, 32'h40,  0, 32'h0,   32'h40};
      tbl[12] = '{0, 1, 1, 0, 32'h0,   1, 32'h40,  32'h44};
      tbl[13] = '{0, 1, 1, 1, 32'h100, 0, 32'h0,   32'h100};
      tbl[14] = '{0, 1, 1, 1, 32'h203, 0, 32'h0,   32'h200};
      tbl[15] = '{0, 1, 1, 0, 32'h0,   1, 32'h200, 32'h204};
      tbl[16] = '{0, 0, 0, 0, 32'h0,   1, 32'h200, 32'h204};
      tbl[17] = '{0, 0, 1, 0, 32'h0,   0, 32'h0,   32'h204};
      tbl[18] = '{0, 1, 1, 0, 32'h0,   1, 32'h204, 32'h208};
      tbl[19] = '{1, 1, 1, 0, 32'h0,   0, 32'h0,   32'h0};
      tbl[20] = '{0, 1, 0, 0, 32'h0,   1, 32'h0,   32'h4};
      tbl[21] = '{0, 1, 0, 0, 32'h0,   1, 32'h0,   32'h8};
      tbl[22] = '{0, 1, 0, 0, 32'h0,   1, 32'h0,   32'h8};
      tbl[23] = '{0, 1, 0, 0, 32'h0,   1, 32'h0,   32'h8};
      tbl[24] = '{0, 1, 1, 0, 32'h0,   1, 32'h4,   32'hC};
      tbl[25] = '{0, 1, 1, 0, 32'h0,   1, 32'h8,   32'h10};
      tbl[26] = '{0, 0, 1, 0, 32'h0,   1, 32'hC,   32'h10};
      tbl[27] = '{0, 0, 1, 0, 32'h0,   0, 32'h0,   32'h10};

      RST = 1'b1;
      fetch_en = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 32'h0;
      fe2 = 1'b0;
      rdy2 = 1'b0;
      #12;
      chk("rst_pc", PC, 32'h0);
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_wrap_pc", PC2, 32'hFFFF_FFF8);

      for (int i = 0; i < NV; i++) begin
         RST = tbl[i].rst;
         fetch_en = tbl[i].fe;
         out_ready = tbl[i].rdy;
         redirect_valid = tbl[i].rv;
         redirect_target = tbl[i].tgt;
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d_valid", i), {31'b0, out_valid},
             {31'b0, tbl[i].ev});
         chk($sformatf("v%0d_PC", i), PC, tbl[i].ePC);
         if (tbl[i].ev) begin
            chk($sformatf("v%0d_out_pc", i), out_pc, tbl[i].epc);
            chk($sformatf("v%0d_out_instr", i), out_instr,
                tbl[i].epc ^ K);
         end
      end
      chk("head10_accepted_once", acc10, 1);
      chk("entry14_never_seen", seen14, 0);

      // Wrap-around from RESET_PC near the top of the address space.
      fetch_en = 1'b0;
      out_ready = 1'b0;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("wrap_rst_pc", PC2, 32'hFFFF_FFF8);
      chk("wrap_rst_valid", {31'b0, out_valid2}, 32'h0);
      RST = 1'b0;
      fe2 = 1'b1;
      rdy2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] e;
         e = 32'hFFFF_FFF8 + 32'(i * 4);
         @(posedge CLK);
         #1;
         chk($sformatf("wrap%0d_valid", i), {31'b0, out_valid2}, 32'h1);
         chk($sformatf("wrap%0d_out_pc", i), out_pc2, e);
         chk($sformatf("wrap%0d_instr", i), out_instr2, e ^ K);
      end
      chk("wrap_pc_after", PC2, 32'h4);
      fe2 = 1'b0;

      // Fill the queue, then pulse reset between clock edges.
      fetch_en = 1'b1;
      out_ready = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      chk("mid_full_valid", {31'b0, out_valid}, 32'h1);
      chk("mid_full_pc", PC, 32'h8);
      RST = 1'b1;
      #1;
      chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
      chk("mid_rst_pc", PC, 32'h0);
      chk("mid_rst_out_pc", out_pc, 32'h0);
      chk("mid_rst_out_instr", out_instr, 32'h0);
      RST = 1'b0;
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      chk("post_rst_out_pc", out_pc, 32'h0);
      chk("post_rst_pc", PC, 32'h4);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter WIDTH, default 32: width of the PC and instruction datapaths.
REQ-002 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset; bits [1:0] are zero.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 PC  output  WIDTH  fetch address presented to the instruction cache.
REQ-006 instruction  input  WIDTH  combinational cache read data for the current PC, valid in the same cycle.
REQ-007 fetch_en  input  1  high permits new fetches; low stops fetching while the queue keeps draining.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_target  input  WIDTH  new fetch address; bits [1:0] are ignored and treated as zero.
REQ-010 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-011 out_ready  input  1  downstream accepts the head entry when out_valid and out_ready are both high.
REQ-012 out_instr  output  WIDTH  head instruction.
REQ-013 out_pc  output  WIDTH  address of the head instruction.

Function
REQ-014 The block SHALL hold a 2-entry FIFO of {pc, instr} pairs with a 2-bit occupancy count (0, 1, 2).
REQ-015 A fetch SHALL occur in a cycle when fetch_en=1, redirect_valid=0, and (count<2 or a pop occurs that cycle).
REQ-016 On a fetch, {PC, instruction} SHALL be pushed, and PC SHALL become PC+4 modulo 2^WIDTH (0xFFFFFFFC wraps to 0).
REQ-017 Fetch-to-output latency SHALL be 1 cycle: an instruction fetched at edge N is visible on out_* after edge N when the FIFO was empty.
REQ-018 With out_ready held high and no redirect, throughput SHALL be one instruction per cycle.
REQ-019 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL come from the head entry.
REQ-020 When count=2 and there is no pop, there SHALL be no fetch, PC SHALL hold, and no entry is lost or overwritten.
REQ-021 When a push and a pop occur in the same cycle, count SHALL be unchanged and the order SHALL be preserved.
REQ-022 On redirect_valid=1, the next edge SHALL flush all entries (count=0), set PC to {redirect_target[WIDTH-1:2],2'b00}, and perform no fetch.
REQ-023 Redirect SHALL take priority over fetch and fetch_en.
REQ-024 A handshake completed in the same cycle as a redirect SHALL count as accepted, and the remaining entries SHALL still be flushed.
REQ-025 Back-to-back redirects SHALL each reload PC, with the last one winning.
REQ-026 When fetch_en=0, PC and the FIFO contents SHALL hold except for pops.

Reset
REQ-027 While RST=1, the block SHALL force PC=RESET_PC, count=0, out_valid=0, and FIFO pointers=0.
REQ-028 While RST=1, out_instr and out_pc SHALL read 0.
REQ-029 A reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-030 On the first edge after RST deasserts, the block SHALL fetch from RESET_PC if fetch_en=1.

Structure
REQ-031 WIDTH, RESET_PC default, and the {pc, instr} fetch-entry type SHALL reside in the shared core package for use by decode.
REQ-032 The FIFO SHALL be a sub-module fetch_queue (2 entries, push/pop/flush, count output); PC sequencing SHALL live in ifetch_unit.

Verification
REQ-033 Reset check: assert RST, then release with fetch_en=1 and out_ready=1 -> PC=0 during reset; out_pc sequence 0, 4, 8, 12 on consecutive cycles from cycle 1.
REQ-034 Backpressure: out_ready=0 for 4 cycles from reset -> count saturates at 2 with out_pc=0 held and PC stuck at 8; on release, out_pc 0, 4, 8 appear with no gaps or duplicates.
REQ-035 Redirect while full: redirect_target=0x3B with count=2 -> next cycle out_valid=0 and PC=0x38; the following cycle out_pc=0x38.
REQ-036 Redirect plus pop in the same cycle: the head (0x10) is accepted exactly once, and the entry at 0x14 never appears.
REQ-037 Wrap: RESET_PC=0xFFFFFFF8 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-038 Mid-stream reset: RST pulsed between edges with count=2 -> out_valid drops immediately, and PC returns to RESET_PC before the next edge.
